// File: rtl/sw_debounce_pulse_if.sv
// Switch-conditioning bus: raw switch levels in, debounced levels and edge strobes out.
interface sw_debounce_pulse_if #(
    parameter int N = 5
) ();
    logic [N-1:0] SW;
    logic [N-1:0] DB;
    logic [N-1:0] RISE;
    logic [N-1:0] FALL;

    modport master (
        output SW,
        input  DB,
        input  RISE,
        input  FALL
    );

    modport slave (
        input  SW,
        output DB,
        output RISE,
        output FALL
    );
endinterface

// File: rtl/sw_debounce_pulse.sv
// Per-channel switch debouncer: 2-flop synchronizer, stability counter and 4-state FSM
// producing a registered clean level plus one-cycle rise/fall strobes.
module sw_debounce_pulse #(
    parameter int N       = 5,
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = $clog2(CNT_MAX)
) (
    input  logic               CLK,
    input  logic               RST_N,
    sw_debounce_pulse_if.slave bus
);

    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] WAIT_HI   = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] WAIT_LO   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N-1:0]       s1_q;
    logic [N-1:0]       s2_q;
    logic [1:0]         state_q [N];
    logic [1:0]         state_d [N];
    logic [CNT_W-1:0]   cnt_q   [N];
    logic [CNT_W-1:0]   cnt_d   [N];
    logic [N-1:0]       db_q;
    logic [N-1:0]       db_d;
    logic [N-1:0]       rise_q;
    logic [N-1:0]       rise_d;
    logic [N-1:0]       fall_q;
    logic [N-1:0]       fall_d;

    // A sample equal to the current level restarts the count at 0; a differing one starts it at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N; i++) begin
            case (state_q[i])
                STABLE_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = WAIT_HI;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                        db_d[i]    = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = WAIT_LO;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                        db_d[i]    = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = STABLE_LO;
                    cnt_d[i]   = '0;
                    db_d[i]    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= bus.SW;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.DB   = db_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Directed bench for sw_debounce_pulse (N=5, CNT_MAX=8) with an expected-value queue.
module tb_sw_debounce_pulse;

    typedef struct packed {
        logic [4:0] db;
        logic [4:0] rise;
        logic [4:0] fall;
    } exp_t;

    logic  clk;
    logic  rst_n;
    exp_t  sb_q [$];
    int    n_checks;
    int    n_err;
    string tag;

    sw_debounce_pulse_if #(.N(5)) bus ();

    sw_debounce_pulse #(
        .N       (5),
        .CNT_MAX (8)
    ) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [4:0] db, input logic [4:0] rise, input logic [4:0] fall);
        exp_t e;
        e.db   = db;
        e.rise = rise;
        e.fall = fall;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL %s scoreboard empty: got 1 entry wanted, have %0d", tag, sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            assert (bus.DB === e.db) else begin
                n_err++;
                $error("FAIL %s DB got %b expected %b", tag, bus.DB, e.db);
            end
            n_checks++;
            assert (bus.RISE === e.rise) else begin
                n_err++;
                $error("FAIL %s RISE got %b expected %b", tag, bus.RISE, e.rise);
            end
            n_checks++;
            assert (bus.FALL === e.fall) else begin
                n_err++;
                $error("FAIL %s FALL got %b expected %b", tag, bus.FALL, e.fall);
            end
        end
    endtask

    // One clock edge, then check the outputs 1 time unit later.
    task automatic cyc(input logic [4:0] db, input logic [4:0] rise, input logic [4:0] fall);
        push_exp(db, rise, fall);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic hold(input int n, input logic [4:0] db);
        for (int k = 0; k < n; k++) cyc(db, 5'b0, 5'b0);
    endtask

    task automatic async_reset_check();
        #3;
        rst_n = 1'b0;
        push_exp(5'b0, 5'b0, 5'b0);
        #1;
        compare_out();
        cyc(5'b0, 5'b0, 5'b0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        bus.SW   = 5'b10101;

        tag = "reset_values";
        @(posedge clk);
        @(posedge clk);
        #1;
        async_reset_check();
        bus.SW = 5'b00000;
        rst_n  = 1'b1;
        hold(3, 5'b00000);

        tag = "clean_press";
        bus.SW = 5'b00001;
        hold(9, 5'b00000);
        cyc(5'b00001, 5'b00001, 5'b00000);
        hold(3, 5'b00001);
        tag = "clean_release";
        bus.SW = 5'b00000;
        hold(9, 5'b00001);
        cyc(5'b00000, 5'b00000, 5'b00001);
        hold(2, 5'b00000);

        tag = "bounce";
        for (int k = 0; k < 4; k++) begin
            bus.SW = (k % 2 == 0) ? 5'b00010 : 5'b00000;
            hold(3, 5'b00000);
        end
        bus.SW = 5'b00010;
        hold(9, 5'b00000);
        cyc(5'b00010, 5'b00010, 5'b00000);
        hold(2, 5'b00010);
        bus.SW = 5'b00000;
        hold(9, 5'b00010);
        cyc(5'b00000, 5'b00000, 5'b00010);
        hold(2, 5'b00000);

        tag = "short_glitch";
        bus.SW = 5'b00100;
        hold(7, 5'b00000);
        bus.SW = 5'b00000;
        hold(12, 5'b00000);

        tag = "simultaneous";
        bus.SW = 5'b11000;
        hold(9, 5'b00000);
        cyc(5'b11000, 5'b11000, 5'b00000);
        hold(4, 5'b11000);
        bus.SW = 5'b00000;
        hold(9, 5'b11000);
        cyc(5'b00000, 5'b00000, 5'b11000);
        hold(2, 5'b00000);

        tag = "reset_mid_count";
        bus.SW = 5'b00001;
        hold(5, 5'b00000);
        async_reset_check();
        rst_n = 1'b1;
        hold(9, 5'b00000);
        cyc(5'b00001, 5'b00001, 5'b00000);
        hold(2, 5'b00001);

        tag = "reset_with_levels";
        bus.SW = 5'b10101;
        hold(9, 5'b00001);
        cyc(5'b10101, 5'b10100, 5'b00000);
        hold(2, 5'b10101);
        async_reset_check();
        rst_n = 1'b1;
        tag = "held_through_reset";
        hold(9, 5'b00000);
        cyc(5'b10101, 5'b10101, 5'b00000);
        hold(2, 5'b10101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
